calc_sequencer: RTL

Top-level control FSM of the four-digit BCD calculator. It sits between the debounced keypad decoder and the operand store / ALU. It turns key strobes into the operand-store control signals (digit load, operand select, result save), sequences the ALU start/done handshake with a timeout, and tells the display which register to show.

---
 rtl/calc_pkg.sv | 55 +++++
 rtl/calc_timeout.sv | 40 ++++
 rtl/calc_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the BCD calculator control path: key codes, FSM states,
// ALU operation and display-select values, plus key classification helpers.
package calc_pkg;

   localparam logic [3:0] KEY_ADD  = 4'd10;
   localparam logic [3:0] KEY_SUB  = 4'd11;
   localparam logic [3:0] KEY_MUL  = 4'd12;
   localparam logic [3:0] KEY_EQ   = 4'd13;
   localparam logic [3:0] KEY_CLR  = 4'd14;
   localparam logic [3:0] KEY_NONE = 4'd15;

   localparam logic [2:0] MAX_DIGITS = 3'd4;

   typedef enum logic [2:0] {
      ST_OP1  = 3'd0,
      ST_OP2  = 3'd1,
      ST_CALC = 3'd2,
      ST_RES  = 3'd3,
      ST_ERR  = 3'd4,
      ST_CLR  = 3'd5,
      ST_SAVE = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      DISP_OP1 = 2'd0,
      DISP_OP2 = 2'd1,
      DISP_RES = 2'd2,
      DISP_ERR = 2'd3
   } disp_sel_e;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_operator(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
   endfunction

   function automatic alu_op_e key_to_op(input logic [3:0] k);
      alu_op_e op;
      case (k)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/calc_timeout.sv
// ALU watchdog: loadable down-counter, expiry flag is combinational from the count.
// Loaded with TIMEOUT_CYCLES-1 on ALU start; expires when it reaches zero while enabled.
module calc_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: key strobes to operand-store controls, ALU start/done with timeout.
// Every output is a flop; a key at cycle N acts at N+1, and keys are dropped while key_ready=0.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic       is_num,
   output logic [3:0] num_val,
   output logic       is_op1,
   output logic       is_op2,
   output logic       save,
   output logic       alu_start,
   output logic [1:0] alu_op,
   input  logic       alu_done,
   input  logic       alu_err,
   output logic [1:0] disp_sel,
   output logic       busy
);

   state_e    state_q, state_d;
   logic [2:0] dcnt_q, dcnt_d;
   logic [3:0] num_val_q, num_val_d;
   alu_op_e   alu_op_q, alu_op_d;
   disp_sel_e disp_sel_q, disp_sel_d;
   logic      key_ready_q, key_ready_d;
   logic      is_num_q, is_num_d;
   logic      is_op1_q, is_op1_d;
   logic      is_op2_q, is_op2_d;
   logic      save_q, save_d;
   logic      alu_start_q, alu_start_d;
   logic      busy_q, busy_d;

   logic key_hit;
   logic to_expired;
   logic to_clr;

   // key_ready_q is the registered gate the keypad saw this cycle
   assign key_hit = key_valid && key_ready_q;
   assign to_clr  = (state_q == ST_CALC) && (state_d != ST_CALC);

   calc_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (to_clr),
      .load_i   (alu_start_d),
      .en_i     (state_q == ST_CALC),
      .expired_o(to_expired)
   );

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      num_val_d   = num_val_q;
      alu_op_d    = alu_op_q;
      is_num_d    = 1'b0;
      alu_start_d = 1'b0;

      case (state_q)
         ST_OP1, ST_OP2: begin
            if (key_hit) begin
               if (is_digit(key_code)) begin
                  if (dcnt_q < MAX_DIGITS) begin
                     is_num_d  = 1'b1;
                     num_val_d = key_code;
                     dcnt_d    = dcnt_q + 3'd1;
                  end
               end else if (is_operator(key_code)) begin
                  alu_op_d = key_to_op(key_code);
                  if (state_q == ST_OP1) begin
                     dcnt_d  = 3'd0;
                     state_d = ST_OP2;
                  end
               end else if (key_code == KEY_EQ) begin
                  if ((state_q == ST_OP2) && (dcnt_q != 3'd0)) begin
                     alu_start_d = 1'b1;
                     state_d     = ST_CALC;
                  end
               end else if (key_code == KEY_CLR) begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_CALC: begin
            // A completion in the same cycle as expiry wins
            if (alu_done) begin
               state_d = alu_err ? ST_ERR : ST_RES;
            end else if (to_expired) begin
               state_d = ST_ERR;
            end
         end
         ST_RES: begin
            if (key_hit) begin
               if (is_operator(key_code)) begin
                  alu_op_d = key_to_op(key_code);
                  state_d  = ST_SAVE;
               end else if (key_code == KEY_CLR) begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_SAVE: begin
            dcnt_d  = 3'd0;
            state_d = ST_OP2;
         end
         ST_ERR: begin
            if (key_hit && (key_code == KEY_CLR)) begin
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            dcnt_d  = 3'd0;
            state_d = ST_OP1;
         end
         default: begin
            state_d = ST_CLR;
         end
      endcase

      // Level outputs follow the state being entered so they line up with it
      is_op1_d    = (state_d == ST_OP1);
      is_op2_d    = (state_d == ST_OP2);
      save_d      = (state_d == ST_SAVE);
      busy_d      = (state_d == ST_CALC);
      key_ready_d = (state_d == ST_OP1) || (state_d == ST_OP2) ||
                    (state_d == ST_RES) || (state_d == ST_ERR);

      disp_sel_d = disp_sel_q;
      case (state_d)
         ST_OP1, ST_CLR: disp_sel_d = DISP_OP1;
         ST_OP2:         disp_sel_d = DISP_OP2;
         ST_RES:         disp_sel_d = DISP_RES;
         ST_ERR:         disp_sel_d = DISP_ERR;
         default:        disp_sel_d = disp_sel_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLR;
         dcnt_q      <= 3'd0;
         num_val_q   <= 4'd0;
         alu_op_q    <= OP_ADD;
         disp_sel_q  <= DISP_OP1;
         key_ready_q <= 1'b0;
         is_num_q    <= 1'b0;
         is_op1_q    <= 1'b0;
         is_op2_q    <= 1'b0;
         save_q      <= 1'b0;
         alu_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         num_val_q   <= num_val_d;
         alu_op_q    <= alu_op_d;
         disp_sel_q  <= disp_sel_d;
         key_ready_q <= key_ready_d;
         is_num_q    <= is_num_d;
         is_op1_q    <= is_op1_d;
         is_op2_q    <= is_op2_d;
         save_q      <= save_d;
         alu_start_q <= alu_start_d;
         busy_q      <= busy_d;
      end
   end

   assign key_ready = key_ready_q;
   assign is_num    = is_num_q;
   assign num_val   = num_val_q;
   assign is_op1    = is_op1_q;
   assign is_op2    = is_op2_q;
   assign save      = save_q;
   assign alu_start = alu_start_q;
   assign alu_op    = alu_op_q;
   assign disp_sel  = disp_sel_q;
   assign busy      = busy_q;

endmodule
